// File: rtl/action_rule_cfg.sv
`default_nettype none
// ============================================================================
// Module   : action_rule_cfg
// Purpose  : Host-command initiator for the action table rule-update port.
//            Optional macro ACTION_CFG_VERIFY_EN adds a read-back check to adds.
// Revision : 1.0  initial release
// ============================================================================
module action_rule_cfg #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [119:0]      cmd_data,
    output logic              ruleSet_valid,
    output logic [129:0]      ruleSet,
    input  logic              result_valid,
    input  logic [119:0]      result,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [119:0]      rsp_data
);

    localparam logic [1:0]        c_op_read      = 2'd0;
    localparam logic [1:0]        c_op_add       = 2'd1;
    localparam logic [1:0]        c_st_ok        = 2'd0;
    localparam logic [1:0]        c_st_timeout   = 2'd1;
    localparam logic [1:0]        c_st_reject    = 2'd3;
    localparam logic [ADDR_W-1:0] c_default_slot = '1;
    localparam logic [7:0]        c_timeout_last = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT_RSP,
        S_RESP
    } state_t;

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_cnt;
`ifdef ACTION_CFG_VERIFY_EN
    localparam logic [1:0] c_st_mismatch = 2'd2;
    logic         r_verify;
    logic [119:0] r_data;
`endif

    logic w_accept;
    logic w_reject;
    logic [1:0] w_rd_status;

    assign w_accept = cmd_valid && cmd_ready;
    // The last entry holds the default action and cannot be overwritten by an add.
    assign w_reject = cmd_op[1] || ((cmd_op == c_op_add) && (cmd_addr == c_default_slot));
`ifdef ACTION_CFG_VERIFY_EN
    assign w_rd_status = (r_verify && (result != r_data)) ? c_st_mismatch : c_st_ok;
`else
    assign w_rd_status = c_st_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= c_op_read;
            r_cnt         <= '0;
            cmd_ready     <= 1'b1;
            ruleSet_valid <= 1'b0;
            ruleSet       <= '0;
            rsp_valid     <= 1'b0;
            rsp_status    <= c_st_ok;
            rsp_data      <= '0;
`ifdef ACTION_CFG_VERIFY_EN
            r_verify      <= 1'b0;
            r_data        <= '0;
`endif
        end else begin
            ruleSet_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_status    <= c_st_ok;
            rsp_data      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        cmd_ready <= 1'b0;
`ifdef ACTION_CFG_VERIFY_EN
                        r_verify  <= 1'b0;
                        r_data    <= cmd_data;
`endif
                        if (w_reject) begin
                            rsp_valid  <= 1'b1;
                            rsp_status <= c_st_reject;
                            r_state    <= S_RESP;
                        end else begin
                            ruleSet_valid <= 1'b1;
                            ruleSet       <= {cmd_op,
                                              (cmd_op == c_op_add) ? cmd_data : 120'b0,
                                              8'(cmd_addr)};
                            r_state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                    if (r_op == c_op_add) begin
`ifndef ACTION_CFG_VERIFY_EN
                        rsp_valid  <= 1'b1;
                        rsp_status <= c_st_ok;
`endif
                        r_state <= S_GAP;
                    end else begin
                        r_state <= S_WAIT_RSP;
                    end
                end
                S_GAP: begin
`ifdef ACTION_CFG_VERIFY_EN
                    // Read back the entry just written; ruleSet still holds its index.
                    ruleSet_valid <= 1'b1;
                    ruleSet       <= {c_op_read, 120'b0, ruleSet[7:0]};
                    r_op          <= c_op_read;
                    r_verify      <= 1'b1;
                    r_state       <= S_ISSUE;
`else
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
`endif
                end
                S_WAIT_RSP: begin
                    // A result arriving on the expiry cycle still takes priority.
                    if (result_valid) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= w_rd_status;
                        rsp_data   <= result;
                        r_state    <= S_RESP;
                    end else if (r_cnt == c_timeout_last) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= c_st_timeout;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/action_rule_cfg.md
Name: action_rule_cfg

Overview:
- Control-plane initiator for the action table's rule-update port.
- Takes one host command at a time (add or read of a 120-bit action rule at a 6-bit address).
- Drives the 130-bit ruleSet word with the timing the action table requires, collects its result, and returns one response per command with a status code.
- Sits between the host/config bus bridge and the action table inside the parser.

Parameters:
- ADDR_W, 6, action-table address width (64 entries; entry 2^ADDR_W-1 is the reserved default-action slot).
- TIMEOUT, 16, cycles waited in WAIT_RSP for result_valid before aborting a read (range 4..255).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  2'd0 read, 2'd1 add, 2'd2/2'd3 unsupported.
- cmd_addr  in  ADDR_W  rule index.
- cmd_data  in  120  rule body: [119:112] nextState, [111:104] typeLocation, [103:96] typeMask, [95:0] fieldLocations.
- ruleSet_valid  out  1  one-cycle strobe to the action table.
- ruleSet  out  130  [129:128] op, [127:8] rule body, [7:0] ruleNum = zero-extended address.
- result_valid  in  1  read-data strobe from the action table.
- result  in  120  read data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_status  out  2  0 ok, 1 timeout, 2 verify mismatch, 3 rejected.
- rsp_data  out  120  read data (read, or verify read-back); 0 otherwise.

Behaviour:

Reset and general rules:
- Reset values: all outputs 0 except cmd_ready = 1. State returns to IDLE; timeout counter and latched command are cleared.
- Reset mid-read: any result_valid arriving after reset is ignored.
- States: IDLE, ISSUE, GAP, WAIT_RSP, RESP.

Command acceptance (cycle C):
- Accepted at C: op, addr and data are latched.
- Reject: op >= 2, or an add to addr = 2^ADDR_W-1. Go to RESP: rsp_valid = 1 with status 3 at C+1. Nothing is driven on ruleSet. IDLE at C+2.

Add:
- C+1, ISSUE: ruleSet_valid = 1, ruleSet = {2'd1, data, addr}.
- C+2, GAP: ruleSet_valid = 0 (mandatory). The action table must never see a command in the cycle directly after an add. rsp_valid = 1, status 0.
- C+3: IDLE.

Read:
- C+1, ISSUE: ruleSet_valid = 1, ruleSet = {2'd0, 120'b0, addr}.
- C+2 onward, WAIT_RSP: nominal result_valid arrives at C+5.
- On result_valid: next cycle rsp_valid = 1, status 0, rsp_data = result (nominal C+6). IDLE the following cycle.
- Timeout counter starts at 0 on entering WAIT_RSP and increments each cycle without result_valid. At TIMEOUT it forces rsp_valid, status 1, rsp_data 0.
- result_valid outside WAIT_RSP is ignored.
- result_valid in the same cycle the counter reaches TIMEOUT: the result wins (status 0).

Pacing:
- ruleSet_valid is never high in two consecutive cycles.
- At most one read is outstanding.
- Back-to-back adds are spaced by at least 3 cycles, from one cmd acceptance to the next.

Optional Feature:
ACTION_CFG_VERIFY_EN:
- When defined, an add does not respond in GAP. Instead:
  - C+3: issue a read of the same address (ISSUE).
  - Then WAIT_RSP as for a read.
  - Response: status 0 if result == latched data, else status 2; rsp_data = read-back value. Nominal response at C+8.
  - A timeout during verify gives status 1.
- When undefined, the add responds at C+2 as above and no read-back logic is synthesized.
- Reads and rejects behave identically in both builds.

Test Plan:
- Reset held 3 cycles, then released → cmd_ready = 1 and all other outputs 0. Release in the middle of a read → the late result_valid produces no rsp.
- Add addr 5, data 120'h00A1_0C_FF_…_1234 accepted at C → ruleSet_valid at C+1 only, ruleSet = {2'd1, data, 8'h05}. At C+2, ruleSet_valid = 0 and rsp_valid = 1, status 0.
- Read addr 5, with the model returning result_valid at C+5 → rsp_valid at C+6 with status 0 and rsp_data equal to the data written. Also check that no ruleSet_valid occurs between C+2 and C+6.
- Read with the model silent, TIMEOUT = 16 → rsp_valid with status 1, rsp_data 0, at C+2+16. A second command is accepted afterwards.
- cmd_op = 2, then an add to addr 63 → each gives rsp status 3 at C+1, with ruleSet_valid never asserted.
- With ACTION_CFG_VERIFY_EN, add addr 7 with the model corrupting bit 0 of the read-back → read issued at C+3, rsp at C+8 with status 2 and rsp_data equal to the corrupted value. With a faithful model, status 0.
